// File: rtl/usb_inject_scheduler.sv
// Queues mouse move commands and slices them into per-frame HID reports,
// one request per USB frame, handshaked with the report mux.
module usb_inject_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned STEP_MAX    = 127,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [7:0]                  cmd_buttons,
  input  logic signed [15:0]          cmd_dx,
  input  logic signed [15:0]          cmd_dy,
  input  logic signed [7:0]           cmd_wheel,
  input  logic                        sof_tick,
  output logic [39:0]                 inject_mouse_report,
  output logic                        inject_mouse_valid,
  input  logic                        inject_mouse_ack,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  timeout_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic signed [16:0] STEP_POS = 17'(STEP_MAX);
  localparam logic signed [16:0] STEP_NEG = -STEP_POS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_SOF,
    S_REQ,
    S_ACK_WAIT
  } state_t;

  state_t state, state_next;

  logic [7:0]        q_buttons [FIFO_DEPTH];
  logic [15:0]       q_dx      [FIFO_DEPTH];
  logic [15:0]       q_dy      [FIFO_DEPTH];
  logic [7:0]        q_wheel   [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_next;

  logic signed [16:0] res_dx, res_dy;
  logic signed [16:0] step_dx, step_dy;
  logic signed [16:0] rem_dx, rem_dy;
  logic [7:0]         cur_buttons, cur_wheel;
  logic               first_slice;
  logic [TW-1:0]      timer;

  logic push, pop, acked, timed_out;

  // 17-bit residuals keep -32768 representable as a positive magnitude
  function automatic logic signed [16:0] clamp_step(input logic signed [16:0] v);
    if (v > STEP_POS) return STEP_POS;
    if (v < STEP_NEG) return STEP_NEG;
    return v;
  endfunction

  assign push    = cmd_valid && cmd_ready;
  assign step_dx = clamp_step(res_dx);
  assign step_dy = clamp_step(res_dy);
  assign rem_dx  = res_dx - step_dx;
  assign rem_dy  = res_dy - step_dy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    acked      = 1'b0;
    timed_out  = 1'b0;
    unique case (state)
      S_IDLE:     if (fifo_level != '0) state_next = S_LOAD;
      S_LOAD:     state_next = S_WAIT_SOF;
      S_WAIT_SOF: if (sof_tick) state_next = S_REQ;
      S_REQ:      state_next = S_ACK_WAIT;
      S_ACK_WAIT: begin
        if (inject_mouse_ack) begin
          acked = 1'b1;
          if (rem_dx == '0 && rem_dy == '0) begin
            pop        = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_WAIT_SOF;
          end
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          timed_out  = 1'b1;
          state_next = S_WAIT_SOF;
        end
      end
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    level_next = fifo_level;
    unique case ({push, pop})
      2'b10:   level_next = fifo_level + LW'(1);
      2'b01:   level_next = fifo_level - LW'(1);
      default: level_next = fifo_level;
    endcase
  end

  // Queue storage needs no reset; only entries below fifo_level are read
  always_ff @(posedge clk) begin
    if (push) begin
      q_buttons[wr_ptr] <= cmd_buttons;
      q_dx[wr_ptr]      <= cmd_dx;
      q_dy[wr_ptr]      <= cmd_dy;
      q_wheel[wr_ptr]   <= cmd_wheel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_level          <= '0;
      cmd_ready           <= 1'b1;
      busy                <= 1'b0;
      res_dx              <= '0;
      res_dy              <= '0;
      cur_buttons         <= '0;
      cur_wheel           <= '0;
      first_slice         <= 1'b0;
      inject_mouse_report <= '0;
      inject_mouse_valid  <= 1'b0;
      timer               <= '0;
      timeout_count       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_level         <= level_next;
      cmd_ready          <= (level_next != LW'(FIFO_DEPTH));
      busy               <= (state_next != S_IDLE) || (level_next != '0);
      inject_mouse_valid <= (state_next == S_ACK_WAIT);
      timer              <= (state == S_ACK_WAIT) ? timer + TW'(1) : '0;

      if (state == S_LOAD) begin
        res_dx      <= {q_dx[rd_ptr][15], q_dx[rd_ptr]};
        res_dy      <= {q_dy[rd_ptr][15], q_dy[rd_ptr]};
        cur_buttons <= q_buttons[rd_ptr];
        cur_wheel   <= q_wheel[rd_ptr];
        first_slice <= 1'b1;
      end

      if (state == S_REQ) begin
        inject_mouse_report <= {8'h00, (first_slice ? cur_wheel : 8'h00),
                                step_dy[7:0], step_dx[7:0], cur_buttons};
      end

      if (acked) begin
        res_dx      <= rem_dx;
        res_dy      <= rem_dy;
        first_slice <= 1'b0;
      end

      if (timed_out && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_usb_inject_scheduler.sv
// Directed bench for usb_inject_scheduler: a slice-list scoreboard predicts every
// report and queue occupancy; literal checks pin the key scenarios.
module tb_usb_inject_scheduler;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [7:0]        cmd_buttons = 8'h00;
  logic signed [15:0] cmd_dx = 16'sd0;
  logic signed [15:0] cmd_dy = 16'sd0;
  logic signed [7:0] cmd_wheel = 8'sd0;
  logic              sof_tick = 1'b0;
  logic [39:0]       inject_mouse_report;
  logic              inject_mouse_valid;
  logic              inject_mouse_ack = 1'b0;
  logic              busy;
  logic [2:0]        fifo_level;
  logic [7:0]        timeout_count;

  int tests = 0;
  int fails = 0;

  // Scoreboard state
  int          m_level = 0;
  int          m_tmo = 0;
  int          m_wait = 0;
  bit          m_sof = 1'b0;
  bit          prev_valid = 1'b0;
  logic [39:0] exp_q[$];
  bit          exp_last[$];
  logic [39:0] got_q[$];
  bit          auto_ack = 1'b1;
  bit          force_ack = 1'b0;

  usb_inject_scheduler dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_buttons         (cmd_buttons),
    .cmd_dx              (cmd_dx),
    .cmd_dy              (cmd_dy),
    .cmd_wheel           (cmd_wheel),
    .sof_tick            (sof_tick),
    .inject_mouse_report (inject_mouse_report),
    .inject_mouse_valid  (inject_mouse_valid),
    .inject_mouse_ack    (inject_mouse_ack),
    .busy                (busy),
    .fifo_level          (fifo_level),
    .timeout_count       (timeout_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expand one command into its report slices straight from the slicing rule
  task automatic gen_slices(input logic [7:0] b, input int dx, input int dy, input logic [7:0] wh);
    int ax, ay, n, ny, sx, sy;
    logic [7:0] bx, by;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    n  = (ax + 126) / 127;
    ny = (ay + 126) / 127;
    if (ny > n) n = ny;
    if (n < 1) n = 1;
    for (int k = 0; k < n; k++) begin
      sx = ax - 127 * k;
      if (sx > 127) sx = 127;
      if (sx < 0) sx = 0;
      sy = ay - 127 * k;
      if (sy > 127) sy = 127;
      if (sy < 0) sy = 0;
      if (dx < 0) sx = -sx;
      if (dy < 0) sy = -sy;
      bx = 8'(sx);
      by = 8'(sy);
      exp_q.push_back({8'h00, (k == 0) ? wh : 8'h00, by, bx, b});
      exp_last.push_back(k == n - 1);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level = 0;
      m_tmo = 0;
      m_wait = 0;
      m_sof = 1'b0;
      prev_valid = 1'b0;
      exp_q.delete();
      exp_last.delete();
    end else begin
      bit accept;
      accept = cmd_valid && (m_level != 4);
      if (sof_tick) m_sof = 1'b1;
      if (inject_mouse_valid && inject_mouse_ack) begin
        got_q.push_back(inject_mouse_report);
        if (exp_q.size() > 0) begin
          if (exp_last[0]) m_level--;
          exp_q.pop_front();
          exp_last.pop_front();
        end
        m_wait = 0;
      end else if (inject_mouse_valid) begin
        m_wait++;
        if (m_wait == 255) begin
          m_wait = 0;
          if (m_tmo < 255) m_tmo++;
        end
      end else begin
        m_wait = 0;
      end
      if (accept) begin
        m_level++;
        gen_slices(cmd_buttons, int'(cmd_dx), int'(cmd_dy), cmd_wheel);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("fifo_level", 64'(fifo_level), 64'(m_level));
      chk("cmd_ready", 64'(cmd_ready), 64'(m_level != 4));
      chk("busy", 64'(busy), 64'(m_level != 0));
      chk("timeout_count", 64'(timeout_count), 64'(m_tmo));
      if (inject_mouse_valid) begin
        if (exp_q.size() == 0) chk("report_unexpected", 64'(inject_mouse_valid), 64'd0);
        else chk("report", 64'(inject_mouse_report), 64'(exp_q[0]));
        if (!prev_valid) begin
          chk("sof_before_req", 64'(m_sof), 64'd1);
          m_sof = 1'b0;
        end
      end
      prev_valid = inject_mouse_valid;
    end
  end

  always @(posedge clk) begin
    #1;
    inject_mouse_ack = force_ack || (auto_ack && inject_mouse_valid && !inject_mouse_ack);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input int dx, input int dy, input int wh);
    cmd_buttons = b;
    cmd_dx      = 16'(dx);
    cmd_dy      = 16'(dy);
    cmd_wheel   = 8'(wh);
    cmd_valid   = 1'b1;
    tick(1);
    cmd_valid   = 1'b0;
  endtask

  task automatic sof();
    sof_tick = 1'b1;
    tick(1);
    sof_tick = 1'b0;
  endtask

  task automatic drain(input int max_frames);
    int f = 0;
    while (busy && f < max_frames) begin
      sof();
      tick(5);
      f++;
    end
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    while (!inject_mouse_valid && c < budget) begin
      tick(1);
      c++;
    end
    chk("valid_wait", 64'(inject_mouse_valid), 64'd1);
  endtask

  initial begin
    int cnt;
    logic [39:0] t;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fifo_level", 64'(fifo_level), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_valid", 64'(inject_mouse_valid), 64'd0);
    chk("rst_report", 64'(inject_mouse_report), 64'd0);
    chk("rst_timeout", 64'(timeout_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Three slices: 127+127+46 in X, -50 only in the first slice
    got_q.delete();
    push(8'h01, 300, -50, 2);
    drain(10);
    chk("r027_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("r027_s0", 64'(got_q[0]), 64'h00_02_CE_7F_01);
      chk("r027_s1", 64'(got_q[1]), 64'h00_00_00_7F_01);
      chk("r027_s2", 64'(got_q[2]), 64'h00_00_00_2E_01);
    end

    got_q.delete();
    push(8'h02, 0, 0, 0);
    drain(5);
    chk("r029_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) chk("r029_rpt", 64'(got_q[0]), 64'h00_00_00_00_02);

    // Acks while no request is pending must not consume anything
    got_q.delete();
    push(8'h08, 0, 0, 0);
    tick(3);
    force_ack = 1'b1;
    tick(3);
    force_ack = 1'b0;
    tick(2);
    chk("r019_no_consume", 64'(got_q.size()), 64'd0);
    chk("r019_level", 64'(fifo_level), 64'd1);
    drain(5);
    if (got_q.size() == 1) chk("r019_rpt", 64'(got_q[0]), 64'h00_00_00_00_08);
    else chk("r019_count", 64'(got_q.size()), 64'd1);

    // Fill the queue, hold a fifth command across the first pop
    got_q.delete();
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i), 0, 0, 0);
    tick(1);
    chk("r028_level_full", 64'(fifo_level), 64'd4);
    chk("r028_ready_low", 64'(cmd_ready), 64'd0);
    cmd_buttons = 8'h14;
    cmd_dx = 16'sd0;
    cmd_dy = 16'sd0;
    cmd_wheel = 8'sd0;
    cmd_valid = 1'b1;
    tick(2);
    chk("r028_no_accept", 64'(fifo_level), 64'd4);
    sof();
    tick(5);
    cmd_valid = 1'b0;
    chk("r028_refill_level", 64'(fifo_level), 64'd4);
    chk("r028_refill_ready", 64'(cmd_ready), 64'd0);
    chk("r028_one_popped", 64'(got_q.size()), 64'd1);
    drain(12);
    chk("r028_total", 64'(got_q.size()), 64'd5);
    if (got_q.size() == 5) chk("r028_last", 64'(got_q[4]), 64'h00_00_00_00_14);

    // Unacked request: abandon after 255 cycles, retry on a later frame
    auto_ack = 1'b0;
    got_q.delete();
    push(8'h04, 5, 0, 1);
    tick(3);
    sof();
    wait_valid(20);
    chk("r030_rpt", 64'(inject_mouse_report), 64'h00_01_00_05_04);
    cnt = 0;
    while (inject_mouse_valid && cnt < 400) begin
      sof_tick = (cnt == 10);
      cnt++;
      tick(1);
    end
    sof_tick = 1'b0;
    chk("r030_valid_cycles", 64'(cnt), 64'd255);
    chk("r030_tmo", 64'(timeout_count), 64'd1);
    tick(10);
    chk("r030_no_rerequest", 64'(inject_mouse_valid), 64'd0);
    auto_ack = 1'b1;
    drain(5);
    chk("r030_retry_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) chk("r030_retry_rpt", 64'(got_q[0]), 64'h00_01_00_05_04);

    // -32768 = 258 * (-127) - 2
    got_q.delete();
    push(8'h00, -32768, 0, 0);
    drain(300);
    chk("r031_count", 64'(got_q.size()), 64'd259);
    if (got_q.size() == 259) begin
      t = got_q[0];
      chk("r031_first_dx", 64'(t[15:8]), 64'h81);
      t = got_q[258];
      chk("r031_last_dx", 64'(t[15:8]), 64'hFE);
    end

    // Reset while a request is pending with three commands queued
    auto_ack = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(8'h20 + i), 1, 1, 0);
    tick(2);
    sof();
    wait_valid(20);
    chk("r032_pre_level", 64'(fifo_level), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r032_valid", 64'(inject_mouse_valid), 64'd0);
    chk("r032_level", 64'(fifo_level), 64'd0);
    chk("r032_busy", 64'(busy), 64'd0);
    chk("r032_ready", 64'(cmd_ready), 64'd1);
    chk("r032_tmo", 64'(timeout_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    auto_ack = 1'b1;
    tick(2);

    // Mixed-sign two-slice command after reset
    got_q.delete();
    push(8'h80, -200, 130, -1);
    drain(6);
    chk("post_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk("post_s0", 64'(got_q[0]), 64'h00_FF_7F_81_80);
      chk("post_s1", 64'(got_q[1]), 64'h00_00_03_B7_80);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
